// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: FSM states, write-port source
// select, and the hard-wired zero register.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    WSEL_NONE      = 2'd0,
    WSEL_PIPE      = 2'd1,
    WSEL_LU_DIRECT = 2'd2,
    WSEL_BUF       = 2'd3
  } wsel_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // x0 is hard-wired, so a write aimed at it carries no information.
  function automatic logic is_live_rd(input logic [4:0] rd);
    return rd != REG_X0;
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for a long-latency result that lost arbitration.
// Load wins over clear; both are synchronous, as is the active-low reset.
module wb_hold_buf
  import wb_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [4:0]       d_rd,
  input  logic [WIDTH-1:0] d_data,
  output logic [4:0]       q_rd,
  output logic [WIDTH-1:0] q_data
);

  logic [4:0]       rd_d,   rd_q;
  logic [WIDTH-1:0] data_d, data_q;

  // next-entry selection: capture, drain-to-empty, or hold
  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    if (load) begin
      rd_d   = d_rd;
      data_d = d_data;
    end else if (clear) begin
      rd_d   = REG_X0;
      data_d = '0;
    end
  end

  // entry storage with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q   <= REG_X0;
      data_q <= '0;
    end else begin
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign q_rd   = rd_q;
  assign q_data = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline W stage
// and a long-latency (mul/div) unit. The pipeline normally wins; a displaced
// LU result waits in a one-entry buffer and, after MAX_WAIT denied cycles, the
// W stage is stalled for one cycle so the buffer can drain.
// Optional: define WB_ARB_FWD_EN to expose the buffered result for forwarding.
//
// state | meaning
// IDLE  | buffer empty, LU offers accepted
// HOLD  | buffered LU result waiting, pipeline writes win
// FORCE | stall_req high, buffer written, pipeline write dropped
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             lu_valid,
  input  logic [4:0]       lu_rd,
  input  logic [WIDTH-1:0] lu_data,
  output logic             lu_ready,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [WIDTH-1:0] rf_wd,
  output logic             stall_req
`ifdef WB_ARB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [WIDTH-1:0] fwd_data
`endif
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_t state_d, state_q;
  logic [3:0] wait_cnt_d, wait_cnt_q;
  logic       stall_req_d, stall_req_q;
  wsel_t      wsel;
  logic       buf_load, buf_clear;
  logic       pipe_act;
  logic [4:0]       buf_rd;
  logic [WIDTH-1:0] buf_data;

  assign pipe_act = RegWriteW && is_live_rd(RdW);

  wb_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (buf_load),
    .clear  (buf_clear),
    .d_rd   (lu_rd),
    .d_data (lu_data),
    .q_rd   (buf_rd),
    .q_data (buf_data)
  );

  // next-state, wait counter and write-source selection
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wsel       = WSEL_NONE;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lu_valid && is_live_rd(lu_rd)) begin
          if (pipe_act) begin
            wsel       = WSEL_PIPE;
            buf_load   = 1'b1;
            wait_cnt_d = 4'd0;
            state_d    = ST_HOLD;
          end else begin
            wsel = WSEL_LU_DIRECT;
          end
        end else if (pipe_act) begin
          wsel = WSEL_PIPE;
        end
      end
      ST_HOLD: begin
        if (pipe_act) begin
          wsel = WSEL_PIPE;
          if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
          if (wait_cnt_d == MAX_WAIT_C) state_d = ST_FORCE;
        end else begin
          wsel       = WSEL_BUF;
          buf_clear  = 1'b1;
          wait_cnt_d = 4'd0;
          state_d    = ST_IDLE;
        end
      end
      ST_FORCE: begin
        wsel       = WSEL_BUF;
        buf_clear  = 1'b1;
        wait_cnt_d = 4'd0;
        state_d    = ST_IDLE;
      end
      default: begin
        wait_cnt_d = 4'd0;
        state_d    = ST_IDLE;
      end
    endcase
    // nothing reaches the register file while reset is held
    if (!rst_n) wsel = WSEL_NONE;
  end

  assign stall_req_d = (state_d == ST_FORCE);

  // write-port mux; zeros when no source is selected
  always_comb begin
    rf_we = 1'b0;
    rf_rd = REG_X0;
    rf_wd = '0;
    case (wsel)
      WSEL_PIPE: begin
        rf_we = 1'b1;
        rf_rd = RdW;
        rf_wd = ResultW;
      end
      WSEL_LU_DIRECT: begin
        rf_we = 1'b1;
        rf_rd = lu_rd;
        rf_wd = lu_data;
      end
      WSEL_BUF: begin
        rf_we = 1'b1;
        rf_rd = buf_rd;
        rf_wd = buf_data;
      end
      default: ;
    endcase
  end

  // state, counter and registered stall with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      stall_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign lu_ready  = rst_n && (state_q == ST_IDLE);
  assign stall_req = stall_req_q;

`ifdef WB_ARB_FWD_EN
  assign fwd_valid = (state_q != ST_IDLE);
  assign fwd_rd    = buf_rd;
  assign fwd_data  = buf_data;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboarded bench for wb_port_arbiter: each driven cycle pushes the
// reference model's expected outputs; a negedge monitor pops and compares.
module tb_wb_port_arbiter;

  localparam int W  = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, RegWriteW, lu_valid;
  logic [4:0]   RdW, lu_rd;
  logic [W-1:0] ResultW, lu_data;
  logic         lu_ready, rf_we, stall_req;
  logic [4:0]   rf_rd;
  logic [W-1:0] rf_wd;
`ifdef WB_ARB_FWD_EN
  logic         fwd_valid;
  logic [4:0]   fwd_rd;
  logic [W-1:0] fwd_data;
`endif

  wb_port_arbiter #(.WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .stall_req (stall_req)
`ifdef WB_ARB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
`endif
  );

  typedef struct {
    logic         we;
    logic [4:0]   rd;
    logic [W-1:0] wd;
    logic         rdy;
    logic         stall;
    logic         fv;
    logic [4:0]   frd;
    logic [W-1:0] fdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: pending LU results, denial count, stall owed next cycle
  logic [4:0]   pend_rd[$];
  logic [W-1:0] pend_data[$];
  int           denials = 0;
  bit           stalling = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit rw, input logic [4:0] rdw,
                      input logic [W-1:0] resw, input bit lv,
                      input logic [4:0] lrd, input logic [W-1:0] ldat,
                      output bit acc);
    exp_t e;
    bit   pipe;
    @(posedge clk);
    #1;
    rst_n = rst; RegWriteW = rw; RdW = rdw; ResultW = resw;
    lu_valid = lv; lu_rd = lrd; lu_data = ldat;
    pipe = rw && (rdw != 5'd0);
    e.we = 1'b0; e.rd = 5'd0; e.wd = '0; e.rdy = 1'b0;
    e.stall = stalling;
    e.fv    = (pend_rd.size() > 0);
    e.frd   = (pend_rd.size() > 0) ? pend_rd[0] : 5'd0;
    e.fdata = (pend_rd.size() > 0) ? pend_data[0] : '0;
    if (!rst) begin
      pend_rd.delete(); pend_data.delete();
      denials = 0; stalling = 1'b0;
    end else if (stalling) begin
      e.we = 1'b1; e.rd = pend_rd.pop_front(); e.wd = pend_data.pop_front();
      stalling = 1'b0;
    end else if (pend_rd.size() > 0) begin
      if (pipe) begin
        e.we = 1'b1; e.rd = rdw; e.wd = resw;
        denials++;
        if (denials >= MW) stalling = 1'b1;
      end else begin
        e.we = 1'b1; e.rd = pend_rd.pop_front(); e.wd = pend_data.pop_front();
      end
    end else begin
      e.rdy = 1'b1;
      if (lv && lrd != 5'd0) begin
        if (pipe) begin
          e.we = 1'b1; e.rd = rdw; e.wd = resw;
          pend_rd.push_back(lrd); pend_data.push_back(ldat);
          denials = 0;
        end else begin
          e.we = 1'b1; e.rd = lrd; e.wd = ldat;
        end
      end else if (pipe) begin
        e.we = 1'b1; e.rd = rdw; e.wd = resw;
      end
    end
    exp_q.push_back(e);
    acc = e.rdy && lv;
  endtask

  exp_t m;
  // monitor: compare the cycle's outputs mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("rf_we",     W'(rf_we),     W'(m.we));
      chk("rf_rd",     W'(rf_rd),     W'(m.rd));
      chk("rf_wd",     rf_wd,         m.wd);
      chk("lu_ready",  W'(lu_ready),  W'(m.rdy));
      chk("stall_req", W'(stall_req), W'(m.stall));
`ifdef WB_ARB_FWD_EN
      chk("fwd_valid", W'(fwd_valid), W'(m.fv));
      chk("fwd_rd",    W'(fwd_rd),    W'(m.frd));
      chk("fwd_data",  fwd_data,      m.fdata);
`endif
    end
  end

  bit           acc;
  bit           offer;
  logic [4:0]   o_rd;
  logic [W-1:0] o_data;

  initial begin
    rst_n = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, 0, 1, 5, 'h77, acc);
    step(0, 1, 3, 'h5, 0, 0, 0, acc);
    // direct LU write
    step(1, 0, 0, 0, 1, 5, 'h1234, acc);
    // collision then drain
    step(1, 1, 3, 'hA, 1, 7, 'hB, acc);
    step(1, 0, 0, 0, 0, 0, 0, acc);
    // continuous pipeline pressure forces a stall
    step(1, 1, 2, 'h11, 1, 9, 'h99, acc);
    for (int i = 0; i < MW; i++) step(1, 1, 4, W'(32'h20 + i), 0, 0, 0, acc);
    step(1, 1, 4, 'h30, 0, 0, 0, acc);
    step(1, 1, 6, 'h31, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, 0, acc);
    // x0 targets
    step(1, 0, 0, 0, 1, 0, 'h55, acc);
    step(1, 1, 0, 'h66, 0, 0, 0, acc);
    step(1, 1, 0, 'h67, 1, 0, 'h68, acc);
    // reset while holding x9
    step(1, 1, 3, 'h1, 1, 9, 'h9, acc);
    step(1, 1, 3, 'h2, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, 0, acc);
    step(1, 0, 0, 0, 0, 0, 0, acc);

    // randomized traffic; the LU holds its offer until accepted
    offer = 1'b0; o_rd = '0; o_data = '0;
    for (int n = 0; n < 800; n++) begin
      if (!offer && $urandom_range(0, 2) == 0) begin
        offer  = 1'b1;
        o_rd   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        o_data = $urandom;
      end
      step($urandom_range(0, 63) != 0,
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom, offer, o_rd, o_data, acc);
      if (acc) offer = 1'b0;
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
